// File: rtl/tcb_engine_arbiter.sv
// Round-robin arbiter that shares one TCB inference engine between NUM_CH image requesters.
// It drives the engine, guards each run with a watchdog, and returns one AXI4-Stream beat per result.
module tcb_engine_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int IMG_WIDTH = 968,
  parameter int OUT_WIDTH = 4,
  parameter int TIMEOUT   = 1023,
  parameter int TO_W      = 10
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset_n,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*IMG_WIDTH-1:0] req_img,
  output logic [NUM_CH-1:0]           req_grant,
  output logic [IMG_WIDTH-1:0]        eng_img,
  output logic                        eng_valid,
  input  logic                        eng_ready,
  input  logic [OUT_WIDTH-1:0]        eng_number,
  output logic                        m_axis_valid,
  output logic [7:0]                  m_axis_data,
  output logic                        m_axis_last,
  input  logic                        m_axis_ready,
  output logic                        busy,
  output logic [15:0]                 done_count,
  output logic [7:0]                  err_count
);

  typedef enum logic [1:0] {IDLE, RUN, SEND} state_t;

  localparam int IW = CH_W + 1;
  localparam logic [IW-1:0] NCH = IW'(NUM_CH);

  state_t               state, state_nxt;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      sel;
  logic [CH_W-1:0]      ch;
  logic [IW-1:0]        idx_w;
  logic                 any_req;
  logic [TO_W-1:0]      to_cnt;
  logic [IMG_WIDTH-1:0] eng_img_reg;
  logic [OUT_WIDTH-1:0] res;
  logic                 flag;
  logic                 timeout_hit;
  logic                 start;
  logic                 handshake;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Descending scan so the last hit is the nearest set bit at or after rr_ptr.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx_w   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx_w = {1'b0, rr_ptr} + IW'(i);
      if (idx_w >= NCH) idx_w = idx_w - NCH;
      if (req_valid[idx_w[CH_W-1:0]]) begin
        any_req = 1'b1;
        sel     = idx_w[CH_W-1:0];
      end
    end
  end

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
  assign start       = (state == IDLE) && any_req;
  assign handshake   = (state == SEND) && m_axis_ready;

  always_comb begin
    state_nxt    = state;
    eng_valid    = 1'b0;
    eng_img      = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    m_axis_data  = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: if (any_req) state_nxt = RUN;
      RUN: begin
        eng_valid = 1'b1;
        eng_img   = eng_img_reg;
        if (eng_ready || timeout_hit) state_nxt = SEND;
      end
      SEND: begin
        m_axis_valid               = 1'b1;
        m_axis_last                = 1'b1;
        m_axis_data[OUT_WIDTH-1:0] = res;
        m_axis_data[CH_W+3:4]      = ch;
        m_axis_data[7]             = flag;
        if (m_axis_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: cleared by reset so an interrupted run can never surface a result.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      req_grant  <= '0;
      to_cnt     <= '0;
      done_count <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_nxt;
      req_grant <= '0;
      if (start) begin
        req_grant <= NUM_CH'(1) << sel;
        to_cnt    <= '0;
      end
      if (state == RUN) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (!eng_ready && timeout_hit) err_count <= sat_inc8(err_count);
      end
      if (handshake) begin
        done_count <= done_count + 16'd1;
        rr_ptr     <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
      end
    end
  end

  // Datapath captures; only observed while the matching state gates them out.
  always_ff @(posedge axi_clk) begin
    if (start) begin
      eng_img_reg <= req_img[sel*IMG_WIDTH +: IMG_WIDTH];
      ch          <= sel;
    end
    if (state == RUN) begin
      if (eng_ready) begin
        res  <= eng_number;
        flag <= 1'b0;
      end else if (timeout_hit) begin
        res  <= '0;
        flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tcb_engine_arbiter.md
Name: tcb_engine_arbiter

Overview:
- Round-robin scheduler that shares one TCB inference engine (top_tcb_121_16_10 style: img_source, valid_top, ready_top, number) between NUM_CH image requesters.
- Latches the granted requester's image, drives the engine, and guards each run with a timeout watchdog.
- Returns each result as a single-beat AXI4-Stream packet tagged with channel ID and error flag.
- Sits between per-channel AXI-S input buffers and the DMA-facing master stream.

Parameters:
- NUM_CH, 4, number of requesters; legal range 2..8.
- CH_W, 2, channel ID width, clogb2(NUM_CH-1); at most 3.
- IMG_WIDTH, 968, image width (121 pixels x 8 bit).
- OUT_WIDTH, 4, engine result width.
- TIMEOUT, 1023, maximum RUN cycles before abort; legal range 2..2^TO_W-1.
- TO_W, 10, timeout counter width.

Ports:
- axi_clk  in  1  clock
- axi_reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_CH  per-channel "image ready" level
- req_img  in  NUM_CH*IMG_WIDTH  channel c image at [c*IMG_WIDTH +: IMG_WIDTH]
- req_grant  out  NUM_CH  one-hot, one-cycle pulse: image latched
- eng_img  out  IMG_WIDTH  image to engine
- eng_valid  out  1  engine run enable (valid_top)
- eng_ready  in  1  engine done (ready_top)
- eng_number  in  OUT_WIDTH  engine result
- m_axis_valid  out  1  result valid
- m_axis_data  out  8  [3:0] number, [CH_W+3:4] channel, [7] timeout flag, other bits 0
- m_axis_last  out  1  equals m_axis_valid (single-beat packets)
- m_axis_ready  in  1  downstream ready
- busy  out  1  state != IDLE
- done_count  out  16  completed result handshakes, wraps 0xFFFF->0
- err_count  out  8  timed-out runs, saturates at 255

Behaviour:
- Async reset (axi_reset_n low):
  - State goes to IDLE; rr_ptr=0.
  - All outputs 0; counters 0.
  - A run in progress is abandoned: eng_valid drops immediately, and no result is emitted after reset releases.
- All other logic registered on posedge axi_clk.
- States: IDLE, RUN, SEND.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_CH.
  - At that edge: load eng_img_reg <= req_img[sel]; ch <= sel; req_grant <= onehot(sel) for exactly one cycle; to_cnt <= 0; go to RUN.
  - If no bit is set, stay in IDLE.
  - req_valid is sampled only in IDLE. A requester must hold its image until it sees its grant, then deassert req_valid within that grant cycle (req_valid still high on the edge leaving SEND is treated as a new request).
- RUN:
  - eng_valid=1; eng_img=eng_img_reg. In IDLE and SEND, eng_img=0 and eng_valid=0.
  - to_cnt increments each cycle.
  - eng_ready=1: res <= eng_number, flag <= 0, go to SEND.
  - Else, when to_cnt==TIMEOUT-1: res <= 0, flag <= 1, err_count+1 (saturating), go to SEND.
  - eng_ready and timeout in the same cycle: eng_ready wins, no error.
- SEND:
  - m_axis_valid=m_axis_last=1; m_axis_data={flag, pad, ch, res}, held stable until handshake.
  - On m_axis_valid & m_axis_ready: done_count+1, rr_ptr <= (ch+1) mod NUM_CH, go to IDLE.
  - Back-pressure has no limit; no timeout applies in SEND.
- eng_ready outside RUN is ignored.
- Latency: req_valid high at edge T gives grant and eng_valid in cycle T..T+1. Engine ready in RUN cycle k gives m_axis_valid from the next cycle. Minimum turnaround from one grant to the next grant is 3 cycles.
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,3,0,... Each channel waits at most NUM_CH-1 runs.

Test Plan:
- Single request: req_valid=0001, engine returns 4'h7 after 5 cycles -> grant=0001 for 1 cycle, eng_valid high 5 cycles, m_axis_data=0x07, last=1, done_count=1.
- All requesting, m_axis_ready=1, engine answers in 3 cycles -> grant order ch0,ch1,ch2,ch3,ch0; channel fields 0,1,2,3,0.
- Engine never ready, TIMEOUT=8 -> eng_valid high exactly 8 cycles; m_axis_data=0x80|(ch<<4); err_count=1. Repeat 300 times -> err_count=255.
- eng_ready asserted on the timeout cycle -> flag=0, engine number delivered, err_count unchanged.
- m_axis_ready held low 20 cycles in SEND -> data stable for all 20 cycles, no new grant, single handshake.
- axi_reset_n pulsed low mid-RUN -> eng_valid and busy drop asynchronously; no m_axis_valid after release; rr_ptr=0, so the next grant goes to the lowest requesting channel.
